stepper_step_sequencer: RTL

- Sequences the stepper coil drive from the control register's enable (bit 0) and direction (bit 1) fields, plus a move command: N steps at a programmed step period.
- Sits between the stepper control register and the coil driver pins.
- Owns the step timer, the phase index, the remaining-step counter and the absolute position counter.

---
 rtl/stepper_step_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/stepper_step_sequencer.sv
// stepper_step_sequencer: runs an N-step move at a programmed step period and drives the coil pins.
// Latency: the new coil value appears one cycle after the step event. done appears together with the final step.
// Backpressure: cmd_ready is high only in IDLE. A request made while busy is not taken and must be held.
//
// Ports:
//   system1000, system1000_rstn : clock and synchronous active-low reset
//   ctrl_reg                    : bit0 enable (0 releases the coils / pauses a move), bit1 direction (1 = forward)
//   period, cmd_valid/cmd_steps : move command; period, steps and direction are sampled at accept
//   cmd_ready, busy, done       : handshake and status (all registered)
//   abort                       : ends a running or paused move
//   coil                        : {A, B, A', B'} drive
//   position                    : absolute step count, wraps modulo 2^COUNT_W
//
// Optional feature macro: STEPPER_HALF_STEP_EN. When defined, ctrl_reg[2] selects half-step mode
// (8-entry table). Full-step mode then walks the two-coil entries 1,3,5,7. The mode is latched at accept.
module stepper_step_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16
) (
    input  logic                system1000,
    input  logic                system1000_rstn,
    input  logic [7:0]          ctrl_reg,
    input  logic [PERIOD_W-1:0] period,
    input  logic                cmd_valid,
    input  logic [COUNT_W-1:0]  cmd_steps,
    output logic                cmd_ready,
    input  logic                abort,
    output logic [3:0]          coil,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  position
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

`ifdef STEPPER_HALF_STEP_EN
    localparam int PH_W = 3;

    // In full-step mode the low phase bit is forced high, so only the two-coil entries are used.
    function automatic logic [3:0] f_coil(input logic [2:0] ph, input logic half);
        logic [2:0] idx;
        idx = half ? ph : (ph | 3'd1);
        case (idx)
            3'd0:    f_coil = 4'b1000;
            3'd1:    f_coil = 4'b1100;
            3'd2:    f_coil = 4'b0100;
            3'd3:    f_coil = 4'b0110;
            3'd4:    f_coil = 4'b0010;
            3'd5:    f_coil = 4'b0011;
            3'd6:    f_coil = 4'b0001;
            default: f_coil = 4'b1001;
        endcase
    endfunction

    logic       r_half;
    logic       w_half_nxt;
    logic [2:0] w_delta;
    logic       w_unused;
    assign w_unused   = ^ctrl_reg[7:3];
    assign w_delta    = r_half ? 3'd1 : 3'd2;
`else
    localparam int PH_W = 2;

    function automatic logic [3:0] f_coil(input logic [1:0] ph);
        case (ph)
            2'd0:    f_coil = 4'b1100;
            2'd1:    f_coil = 4'b0110;
            2'd2:    f_coil = 4'b0011;
            default: f_coil = 4'b1001;
        endcase
    endfunction

    logic [1:0] w_delta;
    logic       w_unused;
    assign w_unused = ^ctrl_reg[7:2];
    assign w_delta  = 2'd1;
`endif

    logic [1:0]          r_state;
    logic [PH_W-1:0]     r_phase;
    logic [COUNT_W-1:0]  r_pos;
    logic [COUNT_W-1:0]  r_rem;
    logic [PERIOD_W-1:0] r_timer;
    logic [PERIOD_W-1:0] r_per;
    logic                r_dir;
    logic [3:0]          r_coil;
    logic                r_busy;
    logic                r_done;
    logic                r_cmd_ready;

    logic [1:0]          w_state_nxt;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [COUNT_W-1:0]  w_pos_nxt;
    logic [COUNT_W-1:0]  w_rem_nxt;
    logic [PERIOD_W-1:0] w_timer_nxt;
    logic                w_done_nxt;
    logic                w_accept;
    logic                w_en;
    logic                w_timer_end;
    logic [3:0]          w_coil_nxt;

    assign w_en        = ctrl_reg[0];
    // r_cmd_ready is only ever high in IDLE, so it also qualifies the state.
    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_timer_end = (r_timer == (r_per - PERIOD_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_pos_nxt   = r_pos;
        w_rem_nxt   = r_rem;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_steps == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_timer_nxt = '0;
                        w_rem_nxt   = cmd_steps;
                    end
                end
            end
            S_RUN: begin
                if (!w_en) begin
                    // Timer freezes; no step is taken in the cycle the enable drops.
                    if (abort) begin
                        w_state_nxt = S_IDLE;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_PAUSE;
                    end
                end else if (w_timer_end) begin
                    w_phase_nxt = r_dir ? (r_phase + w_delta) : (r_phase - w_delta);
                    w_pos_nxt   = r_dir ? (r_pos + COUNT_W'(1)) : (r_pos - COUNT_W'(1));
                    w_rem_nxt   = r_rem - COUNT_W'(1);
                    w_timer_nxt = '0;
                    // A coincident abort still lets this step land; done fires once.
                    if (r_rem == COUNT_W'(1) || abort) begin
                        w_state_nxt = S_IDLE;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end else if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + PERIOD_W'(1);
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else if (w_en) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef STEPPER_HALF_STEP_EN
    assign w_half_nxt = w_accept ? ctrl_reg[2] : r_half;
    assign w_coil_nxt = w_en ? f_coil(w_phase_nxt, w_half_nxt) : 4'b0000;
`else
    assign w_coil_nxt = w_en ? f_coil(w_phase_nxt) : 4'b0000;
`endif

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_pos       <= '0;
            r_rem       <= '0;
            r_timer     <= '0;
            r_per       <= PERIOD_W'(1);
            r_dir       <= 1'b0;
            r_coil      <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
`ifdef STEPPER_HALF_STEP_EN
            r_half      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_pos       <= w_pos_nxt;
            r_rem       <= w_rem_nxt;
            r_timer     <= w_timer_nxt;
            r_coil      <= w_coil_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
`ifdef STEPPER_HALF_STEP_EN
            r_half      <= w_half_nxt;
`endif
            if (w_accept) begin
                // A zero period is treated as one cycle per step.
                r_per <= (period == '0) ? PERIOD_W'(1) : period;
                r_dir <= ctrl_reg[1];
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign coil      = r_coil;
    assign busy      = r_busy;
    assign done      = r_done;
    assign position  = r_pos;

endmodule
